// File: rtl/riscv_pkg.sv
// Shared types and default widths for the core's memory-side blocks.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive IF arbitration losses.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(LIMIT));
    assign o_at_limit = w_at_limit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter: D has priority, IF is forced through after STARVE_LIMIT losses.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_at_limit;
    logic              w_busy;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_d_gnt && if_req),
        .i_clr      (w_if_gnt),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        w_next_state = r_state;
        w_if_gnt     = 1'b0;
        w_d_gnt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req && (!d_req || w_at_limit)) begin
                    w_if_gnt     = 1'b1;
                    w_next_state = BUSY_I;
                end else if (d_req) begin
                    w_d_gnt      = 1'b1;
                    w_next_state = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (w_if_gnt) begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_be    <= '1;
            end else if (w_d_gnt) begin
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_be    <= d_we ? d_be : '1;
            end
            if (r_state == BUSY_I && mem_ready) begin
                r_if_rvalid <= 1'b1;
                r_if_rdata  <= mem_rdata;
            end
            if (r_state == BUSY_D && mem_ready) begin
                r_d_rvalid <= 1'b1;
                r_d_rdata  <= r_we ? '0 : mem_rdata;
            end
        end
    end

    // Memory bus is zeroed outside BUSY so IDLE never presents stale fields.
    assign w_busy    = (r_state != IDLE);
    assign mem_req   = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_addr  = w_busy ? r_addr  : '0;
    assign mem_wdata = w_busy ? r_wdata : '0;
    assign mem_be    = w_busy ? r_be    : '0;

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=4).
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 2 time units after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        #1;
        total++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000",
                            {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
            bad++; $display("FAIL reset_data got addr=%h wdata=%h be=%b ird=%h drd=%h want all 0",
                            mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
        end
        cyc();
        reset = 1'b0;
        // D load granted, then reset while BUSY_D waits on memory
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL rst_dgnt got=%b want=1", d_gnt); end
        cyc();
        d_req = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            bad++; $display("FAIL rst_busy got req=%b addr=%h want req=1 addr=00000200", mem_req, mem_addr);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_memreq got=%b want=0", mem_req); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            total++;
            if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_rvalid[%0d] got=%b want=0", i, d_rvalid); end
        end
        // Arbiter must be IDLE: a lone IF request is granted immediately
        cyc();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        total++;
        if (if_gnt !== 1'b1) begin bad++; $display("FAIL rst_idle_gnt got=%b want=1", if_gnt); end
        cyc();
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1;
        cyc();
        mem_ready = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1) begin
            bad++; $display("FAIL rst_idle_rv got rv=%b rd=%h want rv=1 rd=00000001", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_if_read();
        cyc();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        total++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL if_t0 got gnt=%b dgnt=%b req=%b want 1 0 0", if_gnt, d_gnt, mem_req);
        end
        cyc();
        if_req = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_be !== 4'hF) begin
            bad++; $display("FAIL if_t1 got req=%b we=%b addr=%h be=%b want 1 0 00000100 1111",
                            mem_req, mem_we, mem_addr, mem_be);
        end
        cyc();
        #1;
        total++;
        if (mem_req !== 1'b1 || if_rvalid !== 1'b0) begin
            bad++; $display("FAIL if_t2 got req=%b rv=%b want 1 0", mem_req, if_rvalid);
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h00000013;
        #1;
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL if_t3 got req=%b want=1", mem_req); end
        cyc();
        mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || mem_req !== 1'b0) begin
            bad++; $display("FAIL if_t4 got rv=%b rd=%h req=%b want 1 00000013 0", if_rvalid, if_rdata, mem_req);
        end
        cyc();
        #1;
        total++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h13) begin
            bad++; $display("FAIL if_hold got rv=%b rd=%h want 0 00000013", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        cyc();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        #1;
        total++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            bad++; $display("FAIL sim_first got dgnt=%b igsnt=%b want 1 0", d_gnt, if_gnt);
        end
        cyc();
        d_req = 1'b0;
        #1;
        total++;
        if (mem_addr !== 32'h200 || if_gnt !== 1'b0) begin
            bad++; $display("FAIL sim_busy got addr=%h ignt=%b want 00000200 0", mem_addr, if_gnt);
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        cyc();
        mem_ready = 1'b0;
        #1;
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001 || if_gnt !== 1'b1) begin
            bad++; $display("FAIL sim_handover got drv=%b drd=%h ignt=%b want 1 cafe0001 1",
                            d_rvalid, d_rdata, if_gnt);
        end
        cyc();
        if_req = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            bad++; $display("FAIL sim_if_busy got req=%b addr=%h want 1 00000104", mem_req, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h11;
        cyc();
        mem_ready = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h11) begin
            bad++; $display("FAIL sim_if_rv got rv=%b rd=%h want 1 00000011", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_store();
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        if_req = 1'b1; if_addr = 32'h108;
        #1;
        total++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            bad++; $display("FAIL st_gnt got dgnt=%b ignt=%b want 1 0", d_gnt, if_gnt);
        end
        cyc();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'b1100;
        #1;
        total++;
        if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h300 || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL st_bus got we=%b be=%b addr=%h wd=%h want 1 0011 00000300 deadbeef",
                            mem_we, mem_be, mem_addr, mem_wdata);
        end
        cyc();
        #1;
        total++;
        if (if_gnt !== 1'b0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL st_if_stall got ignt=%b req=%b want 0 1", if_gnt, mem_req);
        end
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        cyc();
        mem_ready = 1'b0;
        #1;
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_gnt !== 1'b1) begin
            bad++; $display("FAIL st_done got drv=%b drd=%h ignt=%b want 1 00000000 1", d_rvalid, d_rdata, if_gnt);
        end
        cyc();
        if_req = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h108) begin
            bad++; $display("FAIL st_if_bus got we=%b be=%b addr=%h want 0 1111 00000108", mem_we, mem_be, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h5;
        cyc();
        mem_ready = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h5) begin
            bad++; $display("FAIL st_if_rv got rv=%b rd=%h want 1 00000005", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        logic exp_drv;
        for (int g = 0; g < 10; g++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h400;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
            mem_ready = 1'b0;
            #1;
            exp_if  = (g % 5 == 4);
            exp_drv = (g > 0) && ((g - 1) % 5 != 4);
            total++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                bad++; $display("FAIL starve_gnt[%0d] got ignt=%b dgnt=%b want %b %b",
                                g, if_gnt, d_gnt, exp_if, !exp_if);
            end
            total++;
            if (d_rvalid !== exp_drv) begin
                bad++; $display("FAIL starve_drv[%0d] got=%b want=%b", g, d_rvalid, exp_drv);
            end
            cyc();
            mem_ready = 1'b1; mem_rdata = 32'(g);
        end
        cyc();
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        #1;
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'd9 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            bad++; $display("FAIL starve_end got rv=%b rd=%h ignt=%b dgnt=%b want 1 00000009 0 0",
                            if_rvalid, if_rdata, if_gnt, d_gnt);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_drv;
        for (int c = 0; c < 10; c++) begin
            cyc();
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600 + 32'(c);
            mem_ready = 1'b1; mem_rdata = 32'(c + 100);
            #1;
            exp_drv = (c >= 2) && (c % 2 == 0);
            total++;
            if (d_gnt !== (c % 2 == 0) || mem_req !== (c % 2 == 1)) begin
                bad++; $display("FAIL b2b_cyc[%0d] got dgnt=%b req=%b want %b %b",
                                c, d_gnt, mem_req, (c % 2 == 0), (c % 2 == 1));
            end
            total++;
            if (d_rvalid !== exp_drv || (exp_drv && d_rdata !== 32'(c + 99))) begin
                bad++; $display("FAIL b2b_rv[%0d] got rv=%b rd=%h want %b %h", c, d_rvalid, d_rdata, exp_drv, 32'(c + 99));
            end
        end
        // IDLE with mem_ready high must not produce a completion
        cyc();
        d_req = 1'b0;
        cyc();
        #1;
        total++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL idle_ready got drv=%b irv=%b req=%b want 0 0 0", d_rvalid, if_rvalid, mem_req);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_simultaneous();
        test_store();
        test_starvation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
